instr_decode_reg: RTL and testbench

Pipeline register and field decoder sitting between instruction fetch and the immediate extender/register-file read. It accepts 32-bit MIPS instruction words over a valid/ready handshake and holds one decoded instruction. It drives the 16-bit immediate and the extension-select bit consumed by the sign-extension stage, plus register specifiers and an illegal-opcode flag. It supports back-pressure and flush.

---
 rtl/instr_decode_reg.sv | 104 ++++++++++
 tb/tb_instr_decode_reg.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_decode_reg.sv
// Fetch-to-decode holding register: splits a MIPS word into fields, flags unsupported encodings, selects zero/sign extension.
// 1-cycle latency; outputs hold while out_ready is low, and in_ready = !out_valid || out_ready gives full throughput.
module instr_decode_reg #(
    parameter int PC_W = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [PC_W-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PC_W-1:0] out_pc,
    output logic [5:0]      opcode,
    output logic [4:0]      rs,
    output logic [4:0]      rt,
    output logic [4:0]      rd,
    output logic [4:0]      shamt,
    output logic [5:0]      funct,
    output logic [15:0]     imm16,
    output logic            ext_sel,
    output logic [25:0]     jtarget,
    output logic            illegal,
    output logic [15:0]     retired_cnt
);

    typedef struct packed {
        logic [31:0]     instr;
        logic [PC_W-1:0] pc;
        logic            ext_sel;
        logic            illegal;
    } hold_t;

    hold_t       hold_q;
    hold_t       hold_d;
    logic        load;
    logic        fire;
    logic [5:0]  in_op;
    logic [5:0]  in_fn;

    assign in_ready = !out_valid || out_ready;
    assign load     = in_valid && in_ready && !flush;
    assign fire     = out_valid && out_ready;

    assign in_op = in_instr[31:26];
    assign in_fn = in_instr[5:0];

    // Decode happens on the input side so the held copy already carries the flags.
    always_comb begin
        hold_d         = '0;
        hold_d.instr   = in_instr;
        hold_d.pc      = in_pc;
        hold_d.ext_sel = (in_op inside {6'h0C, 6'h0D, 6'h0E, 6'h0F});
        case (in_op)
            6'h00: begin
                case (in_fn)
                    6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h08: hold_d.illegal = 1'b0;
                    default:                                  hold_d.illegal = 1'b1;
                endcase
            end
            6'h02, 6'h03, 6'h04, 6'h05,
            6'h08, 6'h09, 6'h0A,
            6'h0C, 6'h0D, 6'h0E, 6'h0F,
            6'h23, 6'h2B:  hold_d.illegal = 1'b0;
            default:       hold_d.illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_q    <= '0;
            out_valid <= 1'b0;
        end else if (load) begin
            hold_q    <= hold_d;
            out_valid <= 1'b1;
        end else if (flush || fire) begin
            out_valid <= 1'b0;
        end
    end

    // Counts consumed outputs even in a flush cycle; wraps naturally at 16 bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retired_cnt <= '0;
        end else if (fire) begin
            retired_cnt <= retired_cnt + 16'd1;
        end
    end

    assign out_pc  = hold_q.pc;
    assign opcode  = hold_q.instr[31:26];
    assign rs      = hold_q.instr[25:21];
    assign rt      = hold_q.instr[20:16];
    assign rd      = hold_q.instr[15:11];
    assign shamt   = hold_q.instr[10:6];
    assign funct   = hold_q.instr[5:0];
    assign imm16   = hold_q.instr[15:0];
    assign jtarget = hold_q.instr[25:0];
    assign ext_sel = hold_q.ext_sel;
    assign illegal = hold_q.illegal;

endmodule

// File: tb/tb_instr_decode_reg.sv
// Directed-vector bench for instr_decode_reg with hand-computed expectations.
module tb_instr_decode_reg;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [5:0]  opcode;
    logic [4:0]  rs, rt, rd, shamt;
    logic [5:0]  funct;
    logic [15:0] imm16;
    logic        ext_sel;
    logic [25:0] jtarget;
    logic        illegal;
    logic [15:0] retired_cnt;

    int vec_cnt;
    int err_cnt;
    logic [15:0] exp_cnt;

    instr_decode_reg #(.PC_W(32)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
        .imm16(imm16), .ext_sel(ext_sel), .jtarget(jtarget), .illegal(illegal),
        .retired_cnt(retired_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc);
        in_valid = v;
        in_instr = ins;
        in_pc    = pc;
    endtask

    initial begin
        vec_cnt = 0; err_cnt = 0;
        reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_cnt", retired_cnt, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // ori $t0,$t0,0x8000 held with out_ready low
        drive(1'b1, 32'h3508_8000, 32'h100);
        tick();
        chk("ori_valid", out_valid, 1);
        chk("ori_opcode", opcode, 6'h0D);
        chk("ori_rs", rs, 8);
        chk("ori_rt", rt, 8);
        chk("ori_imm", imm16, 16'h8000);
        chk("ori_ext", ext_sel, 1);
        chk("ori_illegal", illegal, 0);
        chk("ori_pc", out_pc, 32'h100);
        chk("ori_in_ready", in_ready, 0);
        drive(1'b0, 32'h0, 32'h0);

        // asynchronous reset mid-cycle
        #2 reset = 1'b1;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_opcode", opcode, 0);
        chk("arst_imm", imm16, 0);
        chk("arst_ext", ext_sel, 0);
        chk("arst_pc", out_pc, 0);
        chk("arst_in_ready", in_ready, 1);
        chk("arst_cnt", retired_cnt, 0);
        @(negedge clk);
        reset = 1'b0;

        // addi $t0,$t0,-8
        out_ready = 1'b1;
        drive(1'b1, 32'h2108_FFF8, 32'h104);
        tick();
        chk("addi_valid", out_valid, 1);
        chk("addi_opcode", opcode, 6'h08);
        chk("addi_imm", imm16, 16'hFFF8);
        chk("addi_ext", ext_sel, 0);
        chk("addi_illegal", illegal, 0);
        chk("addi_cnt", retired_cnt, 0);

        // lw $t1,4($zero) then back-pressure for 3 cycles
        drive(1'b1, 32'h8C09_0004, 32'h108);
        tick();
        chk("lw_cnt", retired_cnt, 1);
        out_ready = 1'b0;
        drive(1'b1, 32'h0000_0000, 32'h10C);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_in_ready", in_ready, 0);
            chk("bp_valid", out_valid, 1);
            chk("bp_opcode", opcode, 6'h23);
            chk("bp_rt", rt, 9);
            chk("bp_imm", imm16, 16'h0004);
            chk("bp_pc", out_pc, 32'h108);
            chk("bp_cnt", retired_cnt, 1);
        end
        out_ready = 1'b1;
        #1 chk("rel_in_ready", in_ready, 1);
        tick();
        chk("rel_valid", out_valid, 1);
        chk("rel_pc", out_pc, 32'h10C);
        chk("rel_illegal", illegal, 1);
        chk("rel_cnt", retired_cnt, 2);

        // 20 back-to-back lw words
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, {6'h23, 5'(i), 5'(i + 1), 16'(i * 4)}, 32'h200 + 32'(i * 4));
            tick();
            chk("str_valid", out_valid, 1);
            chk("str_pc", out_pc, 32'h200 + 32'(i * 4));
            chk("str_rs", rs, 32'(i));
            chk("str_imm", imm16, 32'(i * 4));
        end
        chk("str_cnt", retired_cnt, 22);
        drive(1'b0, 32'h0, 32'h0);
        tick();
        chk("str_drain_valid", out_valid, 0);
        chk("str_drain_cnt", retired_cnt, 23);

        // illegal opcode, illegal funct, legal add, jal
        drive(1'b1, 32'hFC00_0000, 32'h300);
        tick();
        chk("ill_op", illegal, 1);
        chk("ill_op_ext", ext_sel, 0);
        chk("ill_op_opcode", opcode, 6'h3F);
        drive(1'b1, 32'h0000_003F, 32'h304);
        tick();
        chk("ill_fn", illegal, 1);
        chk("ill_fn_ext", ext_sel, 0);
        chk("ill_fn_funct", funct, 6'h3F);
        chk("ill_fn_cnt", retired_cnt, 24);
        drive(1'b1, 32'h0109_5020, 32'h308);
        tick();
        chk("add_illegal", illegal, 0);
        chk("add_rd", rd, 10);
        chk("add_rt", rt, 9);
        drive(1'b1, 32'h0C00_0040, 32'h30C);
        tick();
        chk("jal_illegal", illegal, 0);
        chk("jal_target", jtarget, 26'h40);
        chk("jal_cnt", retired_cnt, 26);

        // flush while holding under back-pressure
        out_ready = 1'b0;
        flush = 1'b1;
        drive(1'b1, 32'h3508_1234, 32'h400);
        #1 chk("fl_in_ready", in_ready, 0);
        tick();
        chk("fl_valid", out_valid, 0);
        chk("fl_cnt", retired_cnt, 26);
        // flush with empty stage and a valid input: nothing loads
        chk("fl_empty_in_ready", in_ready, 1);
        tick();
        chk("fl_empty_valid", out_valid, 0);
        chk("fl_empty_pc", out_pc, 32'h30C);
        flush = 1'b0;
        drive(1'b1, 32'h3508_1234, 32'h500);
        tick();
        chk("ld_valid", out_valid, 1);
        chk("ld_pc", out_pc, 32'h500);
        // flush coinciding with a consume still counts it
        flush = 1'b1;
        out_ready = 1'b1;
        drive(1'b1, 32'h2108_0001, 32'h504);
        tick();
        chk("flc_valid", out_valid, 0);
        chk("flc_cnt", retired_cnt, 27);
        flush = 1'b0;

        // run the counter to 0xFFFF, then wrap
        exp_cnt = 16'd27;
        drive(1'b1, 32'h2108_0001, 32'h600);
        tick();
        while (exp_cnt != 16'hFFFF) begin
            tick();
            exp_cnt = exp_cnt + 16'd1;
        end
        chk("wrap_pre", retired_cnt, 16'hFFFF);
        drive(1'b0, 32'h0, 32'h0);
        tick();
        chk("wrap_cnt", retired_cnt, 0);
        chk("wrap_valid", out_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
